// File: rtl/decode_lifo_if.sv
// Bit-stream interface of the decode LIFO: traceback-side input and
// sink-side output handshakes, plus the sticky overflow flag.
interface decode_lifo_if;
    logic InBit;
    logic InValid;
    logic InReady;
    logic OutBit;
    logic OutValid;
    logic OutReady;
    logic Overflow;

    // Environment side: drives traceback bits and the sink ready.
    modport master (
        output InBit,
        output InValid,
        output OutReady,
        input  InReady,
        input  OutBit,
        input  OutValid,
        input  Overflow
    );

    // LIFO side.
    modport slave (
        input  InBit,
        input  InValid,
        input  OutReady,
        output InReady,
        output OutBit,
        output OutValid,
        output Overflow
    );
endinterface

// File: rtl/decode_lifo.sv
// Ping-pong LIFO that turns traceback bits (reverse time order) into
// forward-order decoded bits. One bank fills upward while the other drains
// downward; a bank becomes readable only once it holds a full block.
module decode_lifo #(
    parameter int DEPTH    = 16,
    parameter int WD_DEPTH = 4
) (
    input  logic          Clock,
    input  logic          Reset,
    decode_lifo_if.slave  bus
);

    localparam logic [WD_DEPTH-1:0] ADDR_LAST = WD_DEPTH'(DEPTH - 1);

    logic [DEPTH-1:0]    mem_q [2];
    logic [1:0]          full_q,     full_d;
    logic                wbank_q,    wbank_d;
    logic [WD_DEPTH-1:0] waddr_q,    waddr_d;
    logic                rbank_q,    rbank_d;
    logic [WD_DEPTH-1:0] raddr_q,    raddr_d;
    logic                overflow_q, overflow_d;

    logic in_ready;
    logic out_valid;
    logic wr_acc;
    logic rd_acc;

    // Handshake outputs depend only on registered state.
    assign in_ready     = ~full_q[wbank_q];
    assign out_valid    = full_q[rbank_q];
    assign wr_acc       = bus.InValid & in_ready;
    assign rd_acc       = out_valid & bus.OutReady;

    assign bus.InReady  = in_ready;
    assign bus.OutValid = out_valid;
    assign bus.OutBit   = mem_q[rbank_q][raddr_q];
    assign bus.Overflow = overflow_q;

    // Next-state: write pointer advance, read pointer retreat, bank flags.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        full_d     = full_q;
        wbank_d    = wbank_q;
        waddr_d    = waddr_q;
        rbank_d    = rbank_q;
        raddr_d    = raddr_q;
        overflow_d = overflow_q | (bus.InValid & ~in_ready);

        // Drain first, then fill: a fill and a drain in the same cycle always
        // target different banks, so both updates survive.
        if (rd_acc) begin
            if (raddr_q == '0) begin
                full_d[rbank_q] = 1'b0;
                rbank_d         = ~rbank_q;
                raddr_d         = ADDR_LAST;
            end else begin
                raddr_d = raddr_q - 1'b1;
            end
        end

        if (wr_acc) begin
            if (waddr_q == ADDR_LAST) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
                waddr_d         = '0;
            end else begin
                waddr_d = waddr_q + 1'b1;
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (Reset) begin
            full_q     <= '0;
            wbank_q    <= 1'b0;
            waddr_q    <= '0;
            rbank_q    <= 1'b0;
            raddr_q    <= ADDR_LAST;
            overflow_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            wbank_q    <= wbank_d;
            waddr_q    <= waddr_d;
            rbank_q    <= rbank_d;
            raddr_q    <= raddr_d;
            overflow_q <= overflow_d;
        end
    end

    // Bank storage write.
    always_ff @(posedge Clock) begin
        // NOTE: storage is deliberately not reset; clearing the full flags
        // is enough to make stale contents unreachable.
        if (wr_acc) begin
            mem_q[wbank_q][waddr_q] <= bus.InBit;
        end
    end

endmodule

// File: doc/decode_lifo.md
DECODE_LIFO -- requirements
Module: decode_lifo

Interface
REQ-001 Parameter DEPTH, default 16, is the block length in decoded bits per traceback block; it SHALL be a power of two and at least 4.
REQ-002 Parameter WD_DEPTH, default 4, is the address width; it SHALL equal log2(DEPTH).
REQ-003 Port Clock, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port InBit, input, 1 bit: decoded bit from traceback, in reverse time order.
REQ-006 Port InValid, input, 1 bit: InBit is valid this cycle.
REQ-007 Port InReady, output, 1 bit: the block can accept InBit this cycle.
REQ-008 Port OutBit, output, 1 bit: decoded bit in forward time order.
REQ-009 Port OutValid, output, 1 bit: OutBit is valid this cycle.
REQ-010 Port OutReady, input, 1 bit: the downstream sink accepts OutBit this cycle.
REQ-011 Port Overflow, output, 1 bit: sticky flag; an input bit was offered while InReady was 0.

Function
REQ-012 Storage SHALL be two register banks (bank 0 and bank 1), each DEPTH x 1 bit, with one full flag per bank.
REQ-013 Write side state: wbank (1 bit) and waddr (WD_DEPTH bits).
REQ-014 Read side state: rbank (1 bit) and raddr (WD_DEPTH bits).
REQ-015 InReady SHALL equal ~full[wbank], combinationally from registered state only.
REQ-016 Write accept occurs when InValid && InReady: mem[wbank][waddr] <= InBit and waddr increments.
REQ-017 Bank fill: on the accept where waddr == DEPTH-1, the block SHALL set full[wbank], toggle wbank and set waddr to 0.
REQ-018 OutValid SHALL equal full[rbank]; OutBit SHALL equal mem[rbank][raddr], combinational from registers.
REQ-019 Read accept occurs when OutValid && OutReady: raddr decrements, so each bank drains from address DEPTH-1 down to 0 and the bit order is reversed.
REQ-020 Bank drain: on the read accept where raddr == 0, the block SHALL clear full[rbank], toggle rbank and set raddr to DEPTH-1.
REQ-021 When OutValid is 1 and OutReady is 0, OutBit and raddr SHALL hold.
REQ-022 Simultaneous bank fill and bank drain in one cycle SHALL both take effect, because they act on different banks.
REQ-023 A bank freed in cycle N SHALL make InReady rise in cycle N+1, never in the same cycle.
REQ-024 Latency: OutValid SHALL rise in the cycle after the DEPTH-th accepted write of a block, provided that bank's read turn has come.
REQ-025 Throughput: the block SHALL sustain 1 bit per cycle in and 1 bit per cycle out with no bubbles when both sides stream continuously.
REQ-026 Overflow SHALL be set in the cycle after any cycle with InValid && ~InReady; that bit SHALL be dropped and no state other than Overflow SHALL change.
REQ-027 Overflow SHALL stay set until Reset.
REQ-028 Partial blocks SHALL never be emitted; a bank becomes readable only once it is full.

Reset
REQ-029 When Reset is 1 at a rising edge, the block SHALL clear full[0] and full[1], set wbank=0, waddr=0, rbank=0, raddr=DEPTH-1 and Overflow=0.
REQ-030 Output values during and after reset SHALL be InReady=1, OutValid=0 and Overflow=0.
REQ-031 Bank contents need not be cleared; OutBit is don't-care while OutValid=0.
REQ-032 Reset asserted mid-block SHALL discard all partial and full banks; no stale bit SHALL be emitted afterwards.

Verification (DEPTH=16)
REQ-033 Single block: write bits b0..b15 = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 with OutReady=0 -> OutValid=1 in the cycle after b15; with OutReady=1 the output stream is b15..b0 = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1, after which OutValid=0.
REQ-034 Streaming: 64 continuous writes with OutReady held at 1 -> after the initial 16-cycle latency, one bit per cycle with no gaps; each 16-bit group is reversed; Overflow stays 0.
REQ-035 Backpressure: OutReady=0 while 33 bits are offered -> InReady falls after bit 32; bit 33 is dropped; Overflow=1 on the next cycle and stays 1.
REQ-036 Stall: deassert OutReady for 5 cycles mid-drain -> OutBit and OutValid hold, and the sequence resumes without loss or duplication.
REQ-037 Reset mid-operation: assert Reset after 10 writes into bank 1 while bank 0 is draining -> next cycle OutValid=0, InReady=1, Overflow=0; the next 16 writes emerge reversed from bank 0.
